// File: rtl/medidor_division_pkg.sv
// Shared constants for the division-value meter: FSM encoding and lock counter width.
package medidor_division_pkg;

  localparam logic [0:0] ST_ACQ = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam int         LOCK_W = 4;

endpackage

// File: rtl/medidor_division_sync_edge_det.sv
// Synchronises the asynchronous divided clock into clkm and emits a one-cycle pulse per transition.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkm,
  input  logic reset,
  input  logic fin,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_d_r;

  // Synchroniser chain followed by a one-cycle delay of its output.
  always_ff @(posedge clkm or posedge reset) begin
    if (reset) begin
      sync_r   <= '0;
      sync_d_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], fin};
      sync_d_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_r[SYNC_STAGES-1] ^ sync_d_r;

endmodule

// File: rtl/medidor_division.sv
// Measures the division value of an incoming divided clock by counting clkm cycles between its edges;
// reports lock against repeated values, match against a reference and loss of signal.
module medidor_division
  import medidor_division_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clkm,
  input  logic             reset,
  input  logic             enable,
  input  logic             fin,
  input  logic [WIDTH-1:0] division_ref,
  output logic [WIDTH-1:0] div_meas,
  output logic             meas_valid,
  output logic             locked,
  output logic             match,
  output logic             timeout
);

  localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);

  logic              edge_s;
  logic [0:0]        state_r;
  logic [WIDTH-1:0]  cnt_r;
  logic [LOCK_W-1:0] lock_cnt_r;
  logic [LOCK_W-1:0] lock_next_s;
  logic              same_s;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clkm    (clkm),
    .reset   (reset),
    .fin     (fin),
    .edge_det(edge_s)
  );

  // Saturating successor of the lock counter and "repeat of the previous value" qualifier.
  always_comb begin
    lock_next_s = LOCK_MAX;
    if (lock_cnt_r < LOCK_MAX) begin
      lock_next_s = lock_cnt_r + LOCK_W'(1);
    end else begin
      lock_next_s = LOCK_MAX;
    end
    same_s = (cnt_r == div_meas) && (lock_cnt_r != LOCK_W'(0));
  end

  // Acquisition FSM, interval counter, capture, lock tracking and timeout.
  always_ff @(posedge clkm or posedge reset) begin
    if (reset) begin
      state_r    <= ST_ACQ;
      cnt_r      <= '0;
      lock_cnt_r <= '0;
      div_meas   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state_r    <= ST_ACQ;
        cnt_r      <= '0;
        lock_cnt_r <= '0;
        locked     <= 1'b0;
      end else begin
        case (state_r)
          ST_ACQ: begin
            cnt_r <= '0;
            if (edge_s) begin
              state_r <= ST_RUN;
              timeout <= 1'b0;
            end
          end
          ST_RUN: begin
            // An edge takes priority over the counter reaching its ceiling.
            if (edge_s) begin
              div_meas   <= cnt_r;
              meas_valid <= 1'b1;
              cnt_r      <= '0;
              if (same_s) begin
                lock_cnt_r <= lock_next_s;
                if (lock_next_s == LOCK_MAX) begin
                  locked <= 1'b1;
                end
              end else begin
                lock_cnt_r <= LOCK_W'(1);
                locked     <= 1'b0;
              end
            end else if (cnt_r == CNT_MAX) begin
              timeout    <= 1'b1;
              locked     <= 1'b0;
              lock_cnt_r <= '0;
              cnt_r      <= '0;
              state_r    <= ST_ACQ;
            end else begin
              cnt_r <= cnt_r + WIDTH'(1);
            end
          end
          default: begin
            state_r    <= ST_ACQ;
            cnt_r      <= '0;
            lock_cnt_r <= '0;
            locked     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Match compares the already-registered lock and measurement, so it lags them by one cycle.
  always_ff @(posedge clkm or posedge reset) begin
    if (reset) begin
      match <= 1'b0;
    end else if (!enable) begin
      match <= 1'b0;
    end else begin
      match <= locked && (div_meas == division_ref);
    end
  end

endmodule

// File: tb/tb_medidor_division.sv
// Directed bench for medidor_division: fin is produced by a behavioural divider with a programmable D.
module tb_medidor_division;

  logic       clkm = 1'b0;
  logic       reset;
  logic       enable;
  logic       fin;
  logic [6:0] division_ref;
  logic [6:0] div_meas;
  logic       meas_valid;
  logic       locked;
  logic       match;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  int fin_div  = 5;
  bit fin_run  = 1'b0;
  bit fin_zero = 1'b1;
  int div_cnt  = 0;

  medidor_division #(
    .WIDTH      (7),
    .SYNC_STAGES(2),
    .LOCK_COUNT (4)
  ) dut (
    .clkm        (clkm),
    .reset       (reset),
    .enable      (enable),
    .fin         (fin),
    .division_ref(division_ref),
    .div_meas    (div_meas),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .match       (match),
    .timeout     (timeout)
  );

  always #5 clkm = ~clkm;

  // Divider model: toggles fin every fin_div+1 clkm cycles, holds when stopped, clears when zeroed.
  initial begin
    fin = 1'b0;
    forever begin
      @(posedge clkm);
      #1;
      if (fin_zero) begin
        fin     = 1'b0;
        div_cnt = 0;
      end else if (fin_run) begin
        if (div_cnt >= fin_div) begin
          fin     = ~fin;
          div_cnt = 0;
        end else begin
          div_cnt++;
        end
      end
    end
  end

  task automatic wait_meas(input int max_cycles, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < max_cycles) begin
      @(negedge clkm);
      n++;
      if (meas_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic start_run(input int d);
    @(negedge clkm);
    reset    = 1'b1;
    fin_zero = 1'b1;
    fin_run  = 1'b0;
    @(negedge clkm);
    @(negedge clkm);
    fin_div  = d;
    reset    = 1'b0;
    enable   = 1'b1;
    fin_zero = 1'b0;
    fin_run  = 1'b1;
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    enable       = 1'b0;
    division_ref = 7'd5;
    fin_zero     = 1'b1;
    fin_run      = 1'b0;
    repeat (3) @(negedge clkm);
    checks++;
    if (div_meas !== 7'd0) begin errors++; $display("FAIL reset_div_meas: got %0d expected 0", div_meas); end
    checks++;
    if ({meas_valid, locked, match, timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {meas_valid, locked, match, timeout});
    end
  endtask

  task automatic test_d5;
    int n; bit ok;
    start_run(5);
    division_ref = 7'd5;
    for (int i = 1; i <= 5; i++) begin
      wait_meas(40, n, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL d5_wait%0d: no meas_valid within %0d cycles", i, n); end
      checks++;
      if (div_meas !== 7'd5) begin errors++; $display("FAIL d5_value%0d: got %0d expected 5", i, div_meas); end
      checks++;
      if (locked !== (i >= 4)) begin errors++; $display("FAIL d5_locked%0d: got %b expected %b", i, locked, i >= 4); end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (n != 6) begin errors++; $display("FAIL d5_interval%0d: got %0d expected 6", i, n); end
      end
      if (i == 4) begin
        checks++;
        if (match !== 1'b0) begin errors++; $display("FAIL d5_match_early: got %b expected 0", match); end
        @(negedge clkm);
        checks++;
        if (match !== 1'b1) begin errors++; $display("FAIL d5_match: got %b expected 1", match); end
        checks++;
        if (meas_valid !== 1'b0) begin errors++; $display("FAIL d5_pulse_width: got %b expected 0", meas_valid); end
      end
    end
  endtask

  task automatic test_switch_d9;
    int n; bit ok;
    fin_div = 9;
    for (int i = 1; i <= 4; i++) begin
      wait_meas(40, n, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL d9_wait%0d: no meas_valid within %0d cycles", i, n); end
      checks++;
      if (div_meas !== 7'd9) begin errors++; $display("FAIL d9_value%0d: got %0d expected 9", i, div_meas); end
      checks++;
      if (locked !== (i == 4)) begin errors++; $display("FAIL d9_locked%0d: got %b expected %b", i, locked, i == 4); end
      if (i >= 2) begin
        checks++;
        if (n != 10) begin errors++; $display("FAIL d9_interval%0d: got %0d expected 10", i, n); end
      end
    end
    @(negedge clkm);
    checks++;
    if (match !== 1'b0) begin errors++; $display("FAIL d9_match_ref5: got %b expected 0", match); end
    division_ref = 7'd9;
    @(negedge clkm);
    checks++;
    if (match !== 1'b1) begin errors++; $display("FAIL d9_match_ref9: got %b expected 1", match); end
  endtask

  task automatic test_d0;
    int n; bit ok;
    start_run(0);
    wait_meas(40, n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL d0_wait: no meas_valid within %0d cycles", n); end
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clkm);
      checks++;
      if (meas_valid !== 1'b1 || div_meas !== 7'd0) begin
        errors++; $display("FAIL d0_meas%0d: got valid=%b value=%0d expected valid=1 value=0", i, meas_valid, div_meas);
      end
      checks++;
      if (locked !== (i >= 4)) begin errors++; $display("FAIL d0_locked%0d: got %b expected %b", i, locked, i >= 4); end
    end
  endtask

  task automatic test_d127_timeout;
    int n; bit ok; bit extra;
    start_run(127);
    for (int i = 1; i <= 2; i++) begin
      wait_meas(300, n, ok);
      checks++;
      if (!ok || div_meas !== 7'd127 || timeout !== 1'b0) begin
        errors++; $display("FAIL d127_meas%0d: got ok=%b value=%0d timeout=%b expected 1/127/0", i, ok, div_meas, timeout);
      end
      if (i == 2) begin
        checks++;
        if (n != 128) begin errors++; $display("FAIL d127_interval: got %0d expected 128", n); end
      end
    end
    fin_run = 1'b0;
    n = 0; extra = 1'b0;
    while (timeout !== 1'b1 && n < 300) begin
      @(negedge clkm);
      n++;
      if (meas_valid === 1'b1) extra = 1'b1;
    end
    checks++;
    if (n != 128) begin errors++; $display("FAIL timeout_latency: got %0d expected 128", n); end
    checks++;
    if (extra || locked !== 1'b0 || div_meas !== 7'd127) begin
      errors++; $display("FAIL timeout_state: got extra=%b locked=%b value=%0d expected 0/0/127", extra, locked, div_meas);
    end
    fin_run = 1'b1;
    n = 0;
    while (timeout !== 1'b0 && n < 300) begin
      @(negedge clkm);
      n++;
    end
    checks++;
    if (timeout !== 1'b0 || meas_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got timeout=%b valid=%b expected 0/0", timeout, meas_valid);
    end
    wait_meas(300, n, ok);
    checks++;
    if (!ok || div_meas !== 7'd127 || n != 128) begin
      errors++; $display("FAIL resume_meas: got ok=%b value=%0d cycles=%0d expected 1/127/128", ok, div_meas, n);
    end
  endtask

  task automatic test_enable;
    int n; bit ok; int pulses;
    start_run(5);
    division_ref = 7'd5;
    for (int i = 1; i <= 5; i++) wait_meas(40, n, ok);
    checks++;
    if (locked !== 1'b1 || match !== 1'b1) begin
      errors++; $display("FAIL en_prelock: got locked=%b match=%b expected 1/1", locked, match);
    end
    @(negedge clkm);
    @(negedge clkm);
    enable = 1'b0;
    @(negedge clkm);
    checks++;
    if (locked !== 1'b0 || match !== 1'b0 || div_meas !== 7'd5 || meas_valid !== 1'b0) begin
      errors++; $display("FAIL en_off: got locked=%b match=%b value=%0d valid=%b expected 0/0/5/0", locked, match, div_meas, meas_valid);
    end
    pulses = 0;
    repeat (20) begin
      @(negedge clkm);
      if (meas_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || div_meas !== 7'd5) begin
      errors++; $display("FAIL en_hold: got pulses=%0d value=%0d expected 0/5", pulses, div_meas);
    end
    enable = 1'b1;
    wait_meas(40, n, ok);
    checks++;
    if (!ok || n < 7 || n > 12 || div_meas !== 7'd5 || locked !== 1'b0) begin
      errors++; $display("FAIL en_resume: got ok=%b cycles=%0d value=%0d locked=%b expected 1/7..12/5/0", ok, n, div_meas, locked);
    end
  endtask

  task automatic test_reset_mid;
    int n; bit ok; int pulses;
    start_run(5);
    wait_meas(40, n, ok);
    wait_meas(40, n, ok);
    @(negedge clkm);
    @(negedge clkm);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({div_meas, meas_valid, locked, match, timeout} !== 11'd0) begin
      errors++; $display("FAIL rst_midcount: got value=%0d flags=%b expected 0", div_meas, {meas_valid, locked, match, timeout});
    end
    fin_zero = 1'b1;
    @(negedge clkm);
    @(negedge clkm);
    reset    = 1'b0;
    fin_zero = 1'b0;
    wait_meas(40, n, ok);
    checks++;
    if (!ok || div_meas !== 7'd5) begin errors++; $display("FAIL rst_first_meas: got ok=%b value=%0d expected 1/5", ok, div_meas); end
    wait_meas(40, n, ok);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (!ok || {div_meas, meas_valid, locked, match, timeout} !== 11'd0) begin
      errors++; $display("FAIL rst_on_valid: got ok=%b value=%0d flags=%b expected 1/0/0", ok, div_meas, {meas_valid, locked, match, timeout});
    end
    fin_zero = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clkm);
      if (meas_valid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rst_glitch: got %0d pulses expected 0", pulses); end
    reset    = 1'b0;
    fin_zero = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_meas(40, n, ok);
      checks++;
      if (!ok || div_meas !== 7'd5 || locked !== (i == 4)) begin
        errors++; $display("FAIL rst_relock%0d: got ok=%b value=%0d locked=%b expected 1/5/%b", i, ok, div_meas, locked, i == 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_d5();
    test_switch_d9();
    test_d0();
    test_d127_timeout();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
